// File: rtl/mem_responder.sv
// Memory responder for the teaching CPU: a fixed three-cycle handshake that
// serves word reads/writes to a local RAM and one memory-mapped I/O word
// (switches on read, hex display on write). Unmapped addresses read as zero.
module mem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] sw,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic [15:0] hex_out,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  // IDLE is the capture cycle C0; W1 does the array read; W2 is the cycle in
  // which the CPU loads MDR and in which a write is allowed to commit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Everything the transaction needs is captured in C0 so the CPU-side values
  // in W1/W2 cannot disturb the access.
  logic [15:0] addr_q,  addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q,    wr_d;
  logic [15:0] sw_q,    sw_d;

  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q,   hex_d;
  logic        err_q,   err_d;

  // RAM storage; deliberately left out of reset so contents survive it.
  logic [15:0] mem_q [DEPTH];

  logic                 isIo;
  logic                 isRam;
  logic [ADDR_BITS-1:0] ramIdx;
  logic [15:0]          readVal;
  logic                 ramWe;
  logic                 wrMismatch;

  // Address decode of the captured address; the I/O word wins if it happens
  // to fall inside the RAM window.
  always_comb begin
    isIo   = (addr_q == IO_ADDR);
    isRam  = (addr_q[15:ADDR_BITS] == '0);
    ramIdx = addr_q[ADDR_BITS-1:0];
  end

  // Read mux: switches sampled in C0, a RAM word, or zero for unmapped space.
  always_comb begin
    readVal = 16'h0000;
    if (isIo) begin
      readVal = sw_q;
    end else if (isRam) begin
      readVal = mem_q[ramIdx];
    end
  end

  // A change of the write strobe mid-transaction is only flagged; the value
  // captured in C0 keeps governing the access.
  always_comb begin
    wrMismatch = mem_ena && (mem_wr_ena != wr_q);
  end

  // Next-state logic: walks IDLE->W1->W2, treats a dropped mem_ena as an
  // abort, loads rdata at the end of W1 and decides the write commit in W2.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    sw_d    = sw_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    err_d   = err_q;
    ramWe   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_ena) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = mem_wr_ena;
          sw_d    = sw;
          state_d = W1;
        end
      end

      W1: begin
        if (!mem_ena) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = W2;
          if (wrMismatch) begin
            err_d = 1'b1;
          end
          if (!wr_q) begin
            rdata_d = readVal;
          end
        end
      end

      W2: begin
        state_d = IDLE;
        if (!mem_ena) begin
          err_d = 1'b1;
        end else begin
          if (wrMismatch) begin
            err_d = 1'b1;
          end
          if (wr_q) begin
            if (isIo) begin
              hex_d = wdata_q;
            end else if (isRam) begin
              ramWe = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and data registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      sw_q    <= 16'h0000;
      rdata_q <= 16'h0000;
      hex_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      sw_q    <= sw_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      err_q   <= err_d;
    end
  end

  // RAM write port; a reset in the commit cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && ramWe) begin
      mem_q[ramIdx] <= wdata_q;
    end
  end

  // Outputs: rvalid only in W2 of a read whose enable is still held, so an
  // abort in W2 never shows a valid strobe.
  always_comb begin
    rdata   = rdata_q;
    rvalid  = (state_q == W2) && !wr_q && mem_ena;
    busy    = (state_q == W1) || (state_q == W2);
    hex_out = hex_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of per-cycle vectors built from
// small transaction helpers, then hand-written abort/mismatch/reset sequences.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        mem_ena;
  logic        mem_wr_ena;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] sw;
  logic [15:0] rdata;
  logic        rvalid;
  logic        busy;
  logic [15:0] hex_out;
  logic        err;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic        ena;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] s;
    logic        rv;
    logic [15:0] rd;
    logic        bz;
    logic [15:0] hx;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  logic [15:0] expRd;
  logic [15:0] expHex;
  logic        expErr;

  mem_responder #(
    .ADDR_BITS(10),
    .IO_ADDR  (16'hFFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_ena   (mem_ena),
    .mem_wr_ena(mem_wr_ena),
    .addr      (addr),
    .wdata     (wdata),
    .sw        (sw),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy),
    .hex_out   (hex_out),
    .err       (err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic ena, input logic wr,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] s, input logic rv,
                              input logic [15:0] rd, input logic bz,
                              input logic [15:0] hx, input logic er);
    vec_t v;
    v.rst = rst; v.ena = ena; v.wr = wr; v.a = a; v.d = d; v.s = s;
    v.rv = rv; v.rd = rd; v.bz = bz; v.hx = hx; v.er = er;
    return v;
  endfunction

  function automatic void pushRow(input logic ena, input logic wr,
                                  input logic [15:0] a, input logic [15:0] d,
                                  input logic [15:0] s, input logic rv,
                                  input logic bz);
    vecs.push_back(mk(1'b0, ena, wr, a, d, s, rv, expRd, bz, expHex, expErr));
  endfunction

  function automatic void pushIdle();
    pushRow(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endfunction

  // Three-cycle write; address/data wiggle after C0 to prove they were captured.
  function automatic void pushWrite(input logic [15:0] a, input logic [15:0] d,
                                    input logic [15:0] hexAfter);
    pushRow(1'b1, 1'b1, a, d, 16'h0000, 1'b0, 1'b0);
    pushRow(1'b1, 1'b1, a ^ 16'h0003, ~d, 16'h0000, 1'b0, 1'b1);
    pushRow(1'b1, 1'b1, a ^ 16'h0003, ~d, 16'h0000, 1'b0, 1'b1);
    expHex = hexAfter;
  endfunction

  // Three-cycle read; switches and address change after C0.
  function automatic void pushRead(input logic [15:0] a, input logic [15:0] s,
                                   input logic [15:0] data);
    pushRow(1'b1, 1'b0, a, 16'h0000, s, 1'b0, 1'b0);
    pushRow(1'b1, 1'b0, a ^ 16'h0003, 16'h0000, ~s, 1'b0, 1'b1);
    expRd = data;
    pushRow(1'b1, 1'b0, a ^ 16'h0003, 16'h0000, ~s, 1'b1, 1'b1);
  endfunction

  task automatic checkOutput(input vec_t v, input int id);
    total++;
    if (rvalid !== v.rv) begin
      bad++;
      $display("[TB] FAIL step%0d rvalid got=%0b want=%0b", id, rvalid, v.rv);
    end
    total++;
    if (rdata !== v.rd) begin
      bad++;
      $display("[TB] FAIL step%0d rdata got=%h want=%h", id, rdata, v.rd);
    end
    total++;
    if (busy !== v.bz) begin
      bad++;
      $display("[TB] FAIL step%0d busy got=%0b want=%0b", id, busy, v.bz);
    end
    total++;
    if (hex_out !== v.hx) begin
      bad++;
      $display("[TB] FAIL step%0d hex_out got=%h want=%h", id, hex_out, v.hx);
    end
    total++;
    if (err !== v.er) begin
      bad++;
      $display("[TB] FAIL step%0d err got=%0b want=%0b", id, err, v.er);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, advance.
  task automatic applyStimulus(input vec_t v, input int id);
    reset      = v.rst;
    mem_ena    = v.ena;
    mem_wr_ena = v.wr;
    addr       = v.a;
    wdata      = v.d;
    sw         = v.s;
    #2;
    checkOutput(v, id);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;

    expRd  = 16'h0000;
    expHex = 16'h0000;
    expErr = 1'b0;

    // Table: first row checks the post-reset state.
    pushIdle();
    pushWrite(16'h0000, 16'h0A0A, 16'h0000);
    pushWrite(16'h0001, 16'h1001, 16'h0000);
    pushWrite(16'h0002, 16'h2002, 16'h0000);
    pushWrite(16'h0003, 16'h3003, 16'h0000);
    pushWrite(16'h0007, 16'h7007, 16'h0000);
    pushWrite(16'h0005, 16'hBEEF, 16'h0000);
    pushIdle();
    pushRead(16'h0005, 16'h0000, 16'hBEEF);
    pushIdle();
    pushRead(16'hFFFF, 16'h1234, 16'h1234);
    pushWrite(16'hFFFF, 16'h00A5, 16'h00A5);
    pushIdle();
    pushRead(16'h8000, 16'h5A5A, 16'h0000);
    pushWrite(16'h8000, 16'h5555, 16'h00A5);
    pushIdle();
    pushRead(16'h0000, 16'h0000, 16'h0A0A);
    pushRead(16'h0001, 16'h0000, 16'h1001);
    pushRead(16'h0002, 16'h0000, 16'h2002);
    pushIdle();

    reset      = 1'b1;
    mem_ena    = 1'b0;
    mem_wr_ena = 1'b0;
    addr       = 16'h0000;
    wdata      = 16'h0000;
    sw         = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Read of 0x0001 aborted in W2: no rvalid, err set afterwards.
    applyStimulus(mk(0, 1, 0, 16'h0001, 16'h0, 16'h0, 0, 16'h2002, 0, 16'h00A5, 0), 1000);
    applyStimulus(mk(0, 1, 0, 16'h0001, 16'h0, 16'h0, 0, 16'h2002, 1, 16'h00A5, 0), 1001);
    applyStimulus(mk(0, 0, 0, 16'h0001, 16'h0, 16'h0, 0, 16'h1001, 1, 16'h00A5, 0), 1002);
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h1001, 0, 16'h00A5, 1), 1003);
    applyStimulus(mk(1, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h1001, 0, 16'h00A5, 1), 1004);
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1005);

    // Write strobe dropped during W1/W2: write still commits, err set.
    applyStimulus(mk(0, 1, 1, 16'h0005, 16'hCAFE, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1100);
    applyStimulus(mk(0, 1, 0, 16'h0005, 16'hCAFE, 16'h0, 0, 16'h0000, 1, 16'h0000, 0), 1101);
    applyStimulus(mk(0, 1, 0, 16'h0005, 16'hCAFE, 16'h0, 0, 16'h0000, 1, 16'h0000, 1), 1102);
    applyStimulus(mk(0, 1, 0, 16'h0005, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1), 1103);
    applyStimulus(mk(0, 1, 0, 16'h0005, 16'h0, 16'h0, 0, 16'h0000, 1, 16'h0000, 1), 1104);
    applyStimulus(mk(0, 1, 0, 16'h0005, 16'h0, 16'h0, 1, 16'hCAFE, 1, 16'h0000, 1), 1105);
    applyStimulus(mk(1, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'hCAFE, 0, 16'h0000, 1), 1106);
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1107);

    // Write 0x1111 to 0x0003 aborted in W1: idle next cycle, err set, word kept.
    applyStimulus(mk(0, 1, 1, 16'h0003, 16'h1111, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1200);
    applyStimulus(mk(0, 0, 1, 16'h0003, 16'h1111, 16'h0, 0, 16'h0000, 1, 16'h0000, 0), 1201);
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1), 1202);
    applyStimulus(mk(0, 1, 0, 16'h0003, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1), 1203);
    applyStimulus(mk(0, 1, 0, 16'h0003, 16'h0, 16'h0, 0, 16'h0000, 1, 16'h0000, 1), 1204);
    applyStimulus(mk(0, 1, 0, 16'h0003, 16'h0, 16'h0, 1, 16'h3003, 1, 16'h0000, 1), 1205);
    applyStimulus(mk(1, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h3003, 0, 16'h0000, 1), 1206);
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1207);

    // Hex set to 0x0077, then reset lands in W2 of a write of 0x2222 to 0x0007.
    applyStimulus(mk(0, 1, 1, 16'hFFFF, 16'h0077, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1300);
    applyStimulus(mk(0, 1, 1, 16'hFFFF, 16'h0077, 16'h0, 0, 16'h0000, 1, 16'h0000, 0), 1301);
    applyStimulus(mk(0, 1, 1, 16'hFFFF, 16'h0077, 16'h0, 0, 16'h0000, 1, 16'h0000, 0), 1302);
    applyStimulus(mk(0, 1, 1, 16'h0007, 16'h2222, 16'h0, 0, 16'h0000, 0, 16'h0077, 0), 1303);
    applyStimulus(mk(0, 1, 1, 16'h0007, 16'h2222, 16'h0, 0, 16'h0000, 1, 16'h0077, 0), 1304);
    applyStimulus(mk(1, 1, 1, 16'h0007, 16'h2222, 16'h0, 0, 16'h0000, 1, 16'h0077, 0), 1305);
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1306);
    applyStimulus(mk(0, 1, 0, 16'h0007, 16'h0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0), 1307);
    applyStimulus(mk(0, 1, 0, 16'h0007, 16'h0, 16'h0, 0, 16'h0000, 1, 16'h0000, 0), 1308);
    applyStimulus(mk(0, 1, 0, 16'h0007, 16'h0, 16'h0, 1, 16'h7007, 1, 16'h0000, 0), 1309);
    applyStimulus(mk(0, 0, 0, 16'h0000, 16'h0, 16'h0, 0, 16'h7007, 0, 16'h0000, 0), 1310);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning RAM holds 2^ADDR_BITS 16-bit words.
REQ-002 SHALL have parameter IO_ADDR, default 16'hFFFF, meaning the memory-mapped switch/hex I/O address.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 mem_ena  input  1  CPU memory operation enable; the CPU holds it for exactly 3 consecutive cycles per access.
REQ-006 mem_wr_ena  input  1  write enable; valid when mem_ena=1.
REQ-007 addr  input  16  word address from the CPU MAR.
REQ-008 wdata  input  16  write data from the CPU MDR.
REQ-009 sw  input  16  switch inputs, readable at IO_ADDR.
REQ-010 rdata  output  16  registered read data.
REQ-011 rvalid  output  1  high for the one cycle in which rdata holds the read result.
REQ-012 busy  output  1  high while a transaction is in progress (states W1, W2).
REQ-013 hex_out  output  16  registered hex-display value, written at IO_ADDR.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, W1, W2; IDLE->W1 when mem_ena=1; W1->W2 when mem_ena=1; W2->IDLE unconditionally.
REQ-016 In IDLE with mem_ena=1 SHALL latch addr, wdata, mem_wr_ena and sw (the capture cycle, C0).
REQ-017 Reads: C1 (W1) SHALL read the RAM array into an internal register; the edge ending C1 SHALL load rdata so that rdata is valid and rvalid=1 throughout C2 (W2), the cycle in which the CPU loads MDR.
REQ-018 rvalid SHALL be 0 in every cycle other than W2 of a read; rdata SHALL hold its last value outside W2.
REQ-019 Writes: SHALL commit latched wdata to the decoded target on the edge ending W2, only if mem_ena=1 in W2; rvalid stays 0.
REQ-020 Decode: addr==IO_ADDR -> I/O; addr[15:ADDR_BITS]==0 -> RAM word addr[ADDR_BITS-1:0]; otherwise unmapped.
REQ-021 I/O read SHALL return sw as sampled in C0; I/O write SHALL update hex_out.
REQ-022 Unmapped read SHALL return 16'h0000 with rvalid=1; unmapped write SHALL be dropped; neither sets err.
REQ-023 Abort: mem_ena=0 in W1 or W2 SHALL return the FSM to IDLE next cycle, commit no write, assert no rvalid, and set err=1.
REQ-024 mem_wr_ena differing from its C0 value during W1/W2 SHALL be ignored (C0 value governs) and SHALL set err=1.
REQ-025 Back-to-back: mem_ena=1 in the cycle after W2 SHALL start a new transaction (that cycle is C0).
REQ-026 Write then read of the same address SHALL return the newly written data.
REQ-027 busy SHALL equal (state==W1 || state==W2).

Reset
REQ-028 reset=1 SHALL force state=IDLE, rdata=0, rvalid=0, hex_out=0, err=0 on the next edge; takes priority over all other events.
REQ-029 Reset during W1/W2 SHALL discard the pending transaction; no write SHALL commit.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-031 Write 16'hBEEF to 16'h0005 (mem_ena 3 cycles, wr=1), then read 16'h0005 -> rvalid=1 and rdata=16'hBEEF in the third cycle of the read only.
REQ-032 sw=16'h1234, read 16'hFFFF -> rdata=16'h1234 in W2; write 16'h00A5 to 16'hFFFF -> hex_out=16'h00A5 after W2 edge.
REQ-033 Read 16'h8000 (unmapped, ADDR_BITS=10) -> rdata=16'h0000, rvalid=1, err=0; write 16'h8000 -> no RAM/hex_out change.
REQ-034 Write 16'h1111 to 16'h0003 with mem_ena dropped in W1 -> FSM IDLE, err=1, subsequent read of 16'h0003 returns prior value.
REQ-035 reset asserted in W2 of write 16'h2222 to 16'h0007 -> rvalid=0, err=0, hex_out=0, word 16'h0007 unchanged.
REQ-036 Two back-to-back 3-cycle reads of 16'h0001 and 16'h0002 -> rvalid high in cycles 3 and 6 with the correct stored data.
